disp_scan_ctrl: RTL and testbench

Scan-out controller for the display frame buffer read port. It generates 640×480 VGA timing from a pixel-rate enable and drives the 19-bit read address of the display RAM in raster order. It registers the returned 12-bit RGB444 word onto the VGA pins, with sync and blanking aligned to the RAM read latency. It sits between the display RAM wrapper and the board VGA connector.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_timing_gen.sv | 71 +++++++
 rtl/disp_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the display scan-out path.
// 640x480 VGA timing defaults and frame buffer word sizes.
package disp_pkg;

  localparam int unsigned DISP_H_ACTIVE = 640;
  localparam int unsigned DISP_H_FP     = 16;
  localparam int unsigned DISP_H_SYNC   = 96;
  localparam int unsigned DISP_H_BP     = 48;
  localparam int unsigned DISP_V_ACTIVE = 480;
  localparam int unsigned DISP_V_FP     = 10;
  localparam int unsigned DISP_V_SYNC   = 2;
  localparam int unsigned DISP_V_BP     = 33;

  localparam int unsigned DISP_H_TOTAL =
      DISP_H_ACTIVE + DISP_H_FP + DISP_H_SYNC + DISP_H_BP;
  localparam int unsigned DISP_V_TOTAL =
      DISP_V_ACTIVE + DISP_V_FP + DISP_V_SYNC + DISP_V_BP;

  localparam int unsigned DISP_RAM_LATENCY = 1;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 12;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } frame_state_e;

endpackage

// File: rtl/disp_timing_gen.sv
// Horizontal/vertical raster counters with sync, active and frame-origin decode.
// Counters step only on pixel ticks.
module disp_timing_gen
  import disp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DISP_H_ACTIVE,
  parameter int unsigned H_FP     = DISP_H_FP,
  parameter int unsigned H_SYNC   = DISP_H_SYNC,
  parameter int unsigned H_BP     = DISP_H_BP,
  parameter int unsigned V_ACTIVE = DISP_V_ACTIVE,
  parameter int unsigned V_FP     = DISP_V_FP,
  parameter int unsigned V_SYNC   = DISP_V_SYNC,
  parameter int unsigned V_BP     = DISP_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pix_en_i,
  output logic active_o,
  output logic hs_n_o,
  output logic vs_n_o,
  output logic origin_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]   h_ext, v_ext;

  // Compare in 32-bit space so sync-end bounds never overflow the counter width.
  assign h_ext = 32'(h_cnt_q);
  assign v_ext = 32'(v_cnt_q);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_i) begin
      if (h_ext == HTotal - 1) begin
        h_cnt_d = '0;
        if (v_ext == VTotal - 1) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    active_o = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    hs_n_o   = !((h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC));
    vs_n_o   = !((v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC));
    origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// VGA scan-out controller: raster-order frame buffer reads and a registered
// RGB444 output stage with syncs delayed to match the one-tick read pipeline.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DISP_H_ACTIVE,
  parameter int unsigned H_FP        = DISP_H_FP,
  parameter int unsigned H_SYNC      = DISP_H_SYNC,
  parameter int unsigned H_BP        = DISP_H_BP,
  parameter int unsigned V_ACTIVE    = DISP_V_ACTIVE,
  parameter int unsigned V_FP        = DISP_V_FP,
  parameter int unsigned V_SYNC      = DISP_V_SYNC,
  parameter int unsigned V_BP        = DISP_V_BP,
  parameter int unsigned RAM_LATENCY = DISP_RAM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              disp_en,
  output logic [ADDR_W-1:0] ramaddrb,
  input  logic [PIX_W-1:0]  ramdoutb,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam int unsigned       LatW     = $clog2(RAM_LATENCY + 2);

  logic active, hs_n, vs_n, origin;

  disp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i    (clk),
    .rst_i    (rst),
    .pix_en_i (pix_en),
    .active_o (active),
    .hs_n_o   (hs_n),
    .vs_n_o   (vs_n),
    .origin_o (origin)
  );

  frame_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dly_act_q, dly_act_d;
  logic              dly_hs_q, dly_hs_d;
  logic              dly_vs_q, dly_vs_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic              data_ok;

  // Clocks elapsed since the last tick; RAM data is trusted only once it has settled.
  assign data_ok = 32'(lat_cnt_q) >= RAM_LATENCY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (pix_en && origin && disp_en) state_d = StRun;
      StRun:  if (pix_en && origin && !disp_en) state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    dly_act_d = dly_act_q;
    dly_hs_d  = dly_hs_q;
    dly_vs_d  = dly_vs_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    lat_cnt_d = lat_cnt_q;
    fs_d      = pix_en && origin;
    if (pix_en) begin
      lat_cnt_d = '0;
      // Address tracks the raster incrementally and parks on the last pixel in blanking.
      if (origin) begin
        addr_d = '0;
      end else if (active && (addr_q != AddrLast)) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      dly_act_d = active;
      dly_hs_d  = hs_n;
      dly_vs_d  = vs_n;
      rgb_d     = (dly_act_q && (state_q == StRun) && data_ok) ? ramdoutb : '0;
      hs_d      = dly_hs_q;
      vs_d      = dly_vs_q;
    end else if (!data_ok) begin
      lat_cnt_d = lat_cnt_q + LatW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dly_act_q <= 1'b0;
      dly_hs_q  <= 1'b1;
      dly_vs_q  <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dly_act_q <= dly_act_d;
      dly_hs_q  <= dly_hs_d;
      dly_vs_q  <= dly_vs_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    ramaddrb    = addr_q;
    vga_r       = rgb_q[11:8];
    vga_g       = rgb_q[7:4];
    vga_b       = rgb_q[3:0];
    vga_hs      = hs_q;
    vga_vs      = vs_q;
    frame_start = fs_q;
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl on a shrunken 16x11 raster (8x6 visible)
// with a one-cycle RAM returning addr[11:0]; every tick is also checked against a raster model.
module tb_disp_scan_ctrl;

  localparam int unsigned HA  = 8;
  localparam int unsigned HFP = 2;
  localparam int unsigned HS  = 3;
  localparam int unsigned HBP = 3;
  localparam int unsigned VA  = 6;
  localparam int unsigned VFP = 1;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 2;
  localparam int unsigned HT  = HA + HFP + HS + HBP;
  localparam int unsigned VT  = VA + VFP + VS + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        disp_en = 1'b0;
  logic [18:0] ramaddrb;
  logic [11:0] ramdoutb = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  int checks = 0;
  int errors = 0;

  // Raster model state: mh/mv = counters before the next tick, ph/pv = pixel in the delay stage.
  int mh, mv, ph, pv, exp_addr;
  bit pvalid, pact, mrun, irregular;

  disp_scan_ctrl #(
    .H_ACTIVE    (HA),
    .H_FP        (HFP),
    .H_SYNC      (HS),
    .H_BP        (HBP),
    .V_ACTIVE    (VA),
    .V_FP        (VFP),
    .V_SYNC      (VS),
    .V_BP        (VBP),
    .RAM_LATENCY (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .disp_en     (disp_en),
    .ramaddrb    (ramaddrb),
    .ramdoutb    (ramdoutb),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ramdoutb <= ramaddrb[11:0];

  function automatic bit is_act(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  function automatic bit hs_low(input int h);
    return (h >= HA + HFP) && (h < HA + HFP + HS);
  endfunction

  function automatic bit vs_low(input int v);
    return (v >= VA + VFP) && (v < VA + VFP + VS);
  endfunction

  function automatic int model_addr(input int h, input int v);
    if (is_act(h, v)) return v * HA + h;
    if (v < VA) return v * HA + HA - 1;
    return HA * VA - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; ph = 0; pv = 0;
    exp_addr = 0; pvalid = 0; pact = 0; mrun = 0;
  endtask

  task automatic tick();
    int gap;
    int exp_rgb;
    bit exp_hs, exp_vs, exp_fs;
    gap = irregular ? int'($urandom_range(2, 7)) : 4;
    for (int i = 0; i < gap - 1; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("fs_width", {31'd0, frame_start}, 0);
        chk("addr_hold", {13'd0, ramaddrb}, exp_addr);
      end
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1 pix_en = 1'b0;
    exp_rgb = (pvalid && pact && mrun) ? (model_addr(ph, pv) & 32'hfff) : 0;
    exp_hs  = pvalid ? !hs_low(ph) : 1'b1;
    exp_vs  = pvalid ? !vs_low(pv) : 1'b1;
    exp_fs  = (mh == 0) && (mv == 0);
    if (exp_fs) mrun = disp_en;
    exp_addr = model_addr(mh, mv);
    ph = mh; pv = mv; pact = is_act(mh, mv); pvalid = 1'b1;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    chk("rgb", {20'd0, vga_r, vga_g, vga_b}, exp_rgb);
    chk("hs", {31'd0, vga_hs}, {31'd0, exp_hs});
    chk("vs", {31'd0, vga_vs}, {31'd0, exp_vs});
    chk("addr", {13'd0, ramaddrb}, exp_addr);
    chk("fs", {31'd0, frame_start}, {31'd0, exp_fs});
  endtask

  // Tick until the pixel (h,v) has just been issued on ramaddrb.
  task automatic run_until(input int h, input int v);
    int n;
    n = 0;
    while (!(pvalid && ph == h && pv == v) && n < 2 * HT * VT) begin
      tick();
      n++;
    end
  endtask

  initial begin
    model_reset();
    irregular = 1'b0;

    // Reset held while ticks arrive.
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 pix_en = 1'b1;
      @(posedge clk);
      #1 pix_en = 1'b0;
      @(posedge clk);
      @(posedge clk);
    end
    #1;
    chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 0);
    chk("rst_hs", {31'd0, vga_hs}, 1);
    chk("rst_vs", {31'd0, vga_vs}, 1);
    chk("rst_addr", {13'd0, ramaddrb}, 0);
    chk("rst_fs", {31'd0, frame_start}, 0);
    rst = 1'b0;
    disp_en = 1'b1;

    // Frame 0: first tick is a frame start, display enabled.
    tick();
    chk("first_fs", {31'd0, frame_start}, 1);
    run_until(5, 0);
    chk("addr_5", {13'd0, ramaddrb}, 5);
    tick();
    chk("pix_5_0", {20'd0, vga_r, vga_g, vga_b}, 32'h005);
    run_until(10, 0);
    chk("hs_pre", {31'd0, vga_hs}, 1);
    run_until(11, 0);
    chk("hs_first_low", {31'd0, vga_hs}, 0);
    run_until(14, 0);
    chk("hs_post", {31'd0, vga_hs}, 1);
    run_until(7, 5);
    chk("addr_last", {13'd0, ramaddrb}, 47);
    run_until(1, 7);
    chk("vs_low", {31'd0, vga_vs}, 0);
    run_until(0, 8);
    chk("addr_vblank_hold", {13'd0, ramaddrb}, 47);
    run_until(1, 9);
    chk("vs_high", {31'd0, vga_vs}, 1);
    run_until(15, 10);
    tick();
    chk("f1_fs", {31'd0, frame_start}, 1);
    chk("f1_addr0", {13'd0, ramaddrb}, 0);

    // Frame 1: disp_en dropped mid-frame; pixels continue to the end.
    run_until(0, 3);
    disp_en = 1'b0;
    run_until(4, 5);
    chk("drop_pix_3_5", {20'd0, vga_r, vga_g, vga_b}, 32'h02b);
    run_until(15, 10);
    tick();

    // Frame 2: idle, blank pixels but syncs running; mid-frame enable is deferred.
    run_until(3, 1);
    tick();
    chk("idle_rgb", {20'd0, vga_r, vga_g, vga_b}, 0);
    run_until(11, 1);
    chk("idle_hs_low", {31'd0, vga_hs}, 0);
    run_until(0, 4);
    disp_en = 1'b1;
    run_until(4, 5);
    chk("idle_defer_rgb", {20'd0, vga_r, vga_g, vga_b}, 0);
    run_until(15, 10);
    tick();

    // Frame 3: reset mid-line.
    run_until(5, 2);
    chk("pre_rst_addr", {13'd0, ramaddrb}, 21);
    chk("pre_rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h014);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 0);
    chk("mid_rst_addr", {13'd0, ramaddrb}, 0);
    chk("mid_rst_hs", {31'd0, vga_hs}, 1);
    chk("mid_rst_vs", {31'd0, vga_vs}, 1);
    rst = 1'b0;
    model_reset();
    tick();
    chk("post_rst_fs", {31'd0, frame_start}, 1);
    chk("post_rst_addr", {13'd0, ramaddrb}, 0);

    // Irregular tick spacing through a full frame.
    irregular = 1'b1;
    run_until(5, 0);
    chk("irr_addr_5", {13'd0, ramaddrb}, 5);
    tick();
    chk("irr_pix_5_0", {20'd0, vga_r, vga_g, vga_b}, 32'h005);
    run_until(11, 0);
    chk("irr_hs_low", {31'd0, vga_hs}, 0);
    run_until(1, 7);
    chk("irr_vs_low", {31'd0, vga_vs}, 0);
    run_until(15, 10);
    tick();
    chk("irr_fs", {31'd0, frame_start}, 1);
    run_until(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
